// File: rtl/spi_pkg.sv
// Shared types and limits for the SPI master transmitter.
package spi_pkg;

  // A receiver with a 2-flop SCK synchroniser needs at least this many clocks per SCK half-period.
  localparam int SPI_MIN_HALF_PERIOD = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    DONE
  } spi_master_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period counter for the SPI master: counts 0..HALF_PERIOD-1 and flags the last count.
module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = SPI_MIN_HALF_PERIOD
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = ($clog2(HALF_PERIOD) > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] count_q;

  // Wrapping on the tick keeps the count at zero at the start of every phase.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tick_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master transmitter: shifts a parallel word out MSB first with SCK and active-low SS.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  SCK_o,
  output logic                  MOSI_o,
  output logic                  SS_n_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  if (HALF_PERIOD < SPI_MIN_HALF_PERIOD) begin : g_bad_half_period
    $error("spi_master: HALF_PERIOD must be at least %0d", SPI_MIN_HALF_PERIOD);
  end

  if (DATA_WIDTH < 2) begin : g_bad_data_width
    $error("spi_master: DATA_WIDTH must be at least 2");
  end

  spi_master_state_t     state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_n_q, ss_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  phase_end;
  logic                  timer_clear;

  // Only the three timed phases run the counter; every phase ends on its tick, so it restarts per state.
  assign timer_clear = !(state_q inside {SETUP, SCK_HIGH, SCK_LOW});

  spi_half_period_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (timer_clear),
    .tick_o   (phase_end)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next values of the pins are computed here so every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start_i) begin
          state_d   = SETUP;
          shift_d   = data_in_i;
          bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
          ss_n_d    = 1'b0;
          busy_d    = 1'b1;
          mosi_d    = data_in_i[DATA_WIDTH-1];
        end
      end

      SETUP: begin
        if (phase_end) begin
          state_d = SCK_HIGH;
          sck_d   = 1'b1;
        end
      end

      SCK_HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            ss_n_d  = 1'b1;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            // MOSI moves only on the falling edge, leaving a full half-period either side of each rise.
            state_d   = SCK_LOW;
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            mosi_d    = shift_d[DATA_WIDTH-1];
          end
        end
      end

      SCK_LOW: begin
        if (phase_end) begin
          state_d = SCK_HIGH;
          sck_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign SCK_o  = sck_q;
  assign MOSI_o = mosi_q;
  assign SS_n_o = ss_n_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: 8-bit/HP4 and 16-bit/HP5 instances with a MOSI scoreboard.
module tb_spi_master;

  localparam int DW8  = 8;
  localparam int HP8  = 4;
  localparam int DW16 = 16;
  localparam int HP16 = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  data8 = '0;
  logic        busy8, done8, sck8, mosi8, ss8;

  logic        start16 = 1'b0;
  logic [15:0] data16 = '0;
  logic        busy16, done16, sck16, mosi16, ss16;

  int tests = 0;
  int failures = 0;

  bit q8[$];
  bit q16[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_mosi;
    int         gap;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(DW8), .HALF_PERIOD(HP8)) dut8 (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .start_i  (start8),
    .data_in_i(data8),
    .busy_o   (busy8),
    .done_o   (done8),
    .SCK_o    (sck8),
    .MOSI_o   (mosi8),
    .SS_n_o   (ss8)
  );

  spi_master #(.DATA_WIDTH(DW16), .HALF_PERIOD(HP16)) dut16 (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .start_i  (start16),
    .data_in_i(data16),
    .busy_o   (busy16),
    .done_o   (done16),
    .SCK_o    (sck16),
    .MOSI_o   (mosi16),
    .SS_n_o   (ss16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor for the 8-bit instance: timing of rises, scoreboard bits, MOSI stability, done/busy shape.
  int   cyc8 = 0, accept8 = 0, rise8 = 0, age8 = -1, busyCnt8 = 0, doneTotal8 = 0;
  logic sckPrev8 = 1'b0, ssPrev8 = 1'b1, donePrev8 = 1'b0;
  logic [2*HP8-1:0] hist8 = '0;

  always @(negedge clk) begin
    cyc8++;
    if (!reset_n) begin
      q8.delete();
      age8 = -1; rise8 = 0; busyCnt8 = 0;
      sckPrev8 = 1'b0; ssPrev8 = 1'b1; donePrev8 = 1'b0;
    end else begin
      hist8 = {hist8[2*HP8-2:0], mosi8};
      if (ssPrev8 && !ss8) begin
        accept8 = cyc8; rise8 = 0; busyCnt8 = 0;
      end
      if (busy8) busyCnt8++;
      if (sck8 && !sckPrev8) begin
        rise8++;
        checkOutput("rise8_time", cyc8, accept8 + HP8 + (rise8 - 1) * 2 * HP8);
        if (q8.size() == 0) checkOutput("rise8_unexpected", rise8, 0);
        else checkOutput("mosi8_bit", 32'(mosi8), 32'(q8.pop_front()));
        age8 = 0;
      end else if (age8 >= 0) begin
        age8++;
      end
      if (age8 == HP8 - 1) begin
        checkOutput("mosi8_stable", 32'(hist8 == {2*HP8{hist8[0]}}), 1);
        age8 = -1;
      end
      if (donePrev8) checkOutput("done8_width", 32'(done8), 0);
      if (done8 && !donePrev8) begin
        doneTotal8++;
        checkOutput("done8_time", cyc8, accept8 + 2 * DW8 * HP8);
        checkOutput("done8_rises", rise8, DW8);
        checkOutput("busy8_cycles", busyCnt8, 2 * DW8 * HP8);
        checkOutput("done8_ss_busy", 32'({ss8, busy8}), 32'b10);
        checkOutput("q8_empty", q8.size(), 0);
      end
      sckPrev8 = sck8; ssPrev8 = ss8; donePrev8 = done8;
    end
  end

  // Same checks for the 16-bit instance.
  int   cyc16 = 0, accept16 = 0, rise16 = 0, age16 = -1, busyCnt16 = 0, doneTotal16 = 0;
  logic sckPrev16 = 1'b0, ssPrev16 = 1'b1, donePrev16 = 1'b0;
  logic [2*HP16-1:0] hist16 = '0;

  always @(negedge clk) begin
    cyc16++;
    if (!reset_n) begin
      q16.delete();
      age16 = -1; rise16 = 0; busyCnt16 = 0;
      sckPrev16 = 1'b0; ssPrev16 = 1'b1; donePrev16 = 1'b0;
    end else begin
      hist16 = {hist16[2*HP16-2:0], mosi16};
      if (ssPrev16 && !ss16) begin
        accept16 = cyc16; rise16 = 0; busyCnt16 = 0;
      end
      if (busy16) busyCnt16++;
      if (sck16 && !sckPrev16) begin
        rise16++;
        checkOutput("rise16_time", cyc16, accept16 + HP16 + (rise16 - 1) * 2 * HP16);
        if (q16.size() == 0) checkOutput("rise16_unexpected", rise16, 0);
        else checkOutput("mosi16_bit", 32'(mosi16), 32'(q16.pop_front()));
        age16 = 0;
      end else if (age16 >= 0) begin
        age16++;
      end
      if (age16 == HP16 - 1) begin
        checkOutput("mosi16_stable", 32'(hist16 == {2*HP16{hist16[0]}}), 1);
        age16 = -1;
      end
      if (donePrev16) checkOutput("done16_width", 32'(done16), 0);
      if (done16 && !donePrev16) begin
        doneTotal16++;
        checkOutput("done16_time", cyc16, accept16 + 2 * DW16 * HP16);
        checkOutput("done16_rises", rise16, DW16);
        checkOutput("busy16_cycles", busyCnt16, 2 * DW16 * HP16);
        checkOutput("done16_ss_busy", 32'({ss16, busy16}), 32'b10);
        checkOutput("q16_empty", q16.size(), 0);
      end
      sckPrev16 = sck16; ssPrev16 = ss16; donePrev16 = done16;
    end
  end

  // Pushes the expected MOSI bits, then raises start for one clock and scrambles data after acceptance.
  task automatic applyStimulus(input bit wide, input logic [15:0] data, input logic [15:0] expBits);
    if (wide) begin
      for (int i = DW16 - 1; i >= 0; i--) q16.push_back(expBits[i]);
      start16 = 1'b1;
      data16 = data;
    end else begin
      for (int i = DW8 - 1; i >= 0; i--) q8.push_back(expBits[i]);
      start8 = 1'b1;
      data8 = data[7:0];
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    data8 = 8'($urandom);
    data16 = 16'($urandom);
    #1;
    checkOutput(wide ? "accept16_ss_busy" : "accept8_ss_busy",
                32'(wide ? {ss16, busy16} : {ss8, busy8}), 32'b01);
  endtask

  task automatic waitDone(input bit wide, input int budget);
    int n = 0;
    while (!(wide ? done16 : done8) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) checkOutput(wide ? "done16_timeout" : "done8_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int doneBefore;

    vecs[0] = '{data: 8'hA5, exp_mosi: 8'b1010_0101, gap: 1};
    vecs[1] = '{data: 8'h3C, exp_mosi: 8'b0011_1100, gap: 3};
    vecs[2] = '{data: 8'h00, exp_mosi: 8'b0000_0000, gap: 2};
    vecs[3] = '{data: 8'hFF, exp_mosi: 8'b1111_1111, gap: 1};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset8_idle", 32'({sck8, mosi8, ss8, busy8, done8}), 32'b00100);
    checkOutput("reset16_idle", 32'({sck16, mosi16, ss16, busy16, done16}), 32'b00100);
    reset_n = 1'b1;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      checkOutput("idle8", 32'({sck8, mosi8, ss8, busy8, done8}), 32'b00100);
      checkOutput("idle16", 32'({sck16, mosi16, ss16, busy16, done16}), 32'b00100);
    end

    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, {8'h00, vecs[v].data}, {8'h00, vecs[v].exp_mosi});
      waitDone(1'b0, 200);
      repeat (vecs[v].gap) @(negedge clk);
      #1;
    end
    checkOutput("done8_count_table", doneTotal8, 4);

    // start pulsed mid-transfer with new data must be ignored; next start lands on the first IDLE cycle.
    applyStimulus(1'b0, 16'h00A5, 16'h00A5);
    repeat (20) @(negedge clk);
    start8 = 1'b1;
    data8 = 8'h00;
    @(negedge clk);
    #1;
    start8 = 1'b0;
    waitDone(1'b0, 200);
    @(negedge clk);
    #1;
    checkOutput("gap_idle8", 32'({ss8, busy8, done8}), 32'b100);
    applyStimulus(1'b0, 16'h00FF, 16'h00FF);
    waitDone(1'b0, 200);
    @(negedge clk);
    #1;

    // Reset after the third rise: outputs go idle before the next clock edge and no done appears.
    applyStimulus(1'b0, 16'h003C, 16'h003C);
    n = 0;
    while (rise8 < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) checkOutput("rise8_wait_timeout", 0, 1);
    doneBefore = doneTotal8;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset8_idle", 32'({sck8, mosi8, ss8, busy8, done8}), 32'b00100);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("no_done_after_abort", doneTotal8, doneBefore);
    applyStimulus(1'b0, 16'h003C, 16'h003C);
    waitDone(1'b0, 200);
    @(negedge clk);
    #1;

    applyStimulus(1'b1, 16'h8001, 16'h8001);
    waitDone(1'b1, 400);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("done8_count_total", doneTotal8, 7);
    checkOutput("done16_count_total", doneTotal16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
